// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding, NOP word,
// PC step and the word-alignment helper.
package ifu_pkg;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_IDLE = 2'd3
   } ifu_state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] PC_INC   = 32'd4;

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_ibus_if.sv
// Instruction-bus interface between the fetch unit (master) and memory (slave).
interface ifu_ibus_if;

   // Handshake: the master holds ibus_req_o/ibus_addr_o; a request is accepted
   // in a cycle where ibus_req_o & ibus_gnt_i. Exactly one ibus_rvalid_i pulse
   // (carrying ibus_rdata_i) follows each accepted request, at least one cycle
   // after the grant. Only one request is ever outstanding.
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;

   modport master (
      output ibus_req_o,
      output ibus_addr_o,
      input  ibus_gnt_i,
      input  ibus_rvalid_i,
      input  ibus_rdata_i
   );

   modport slave (
      input  ibus_req_o,
      input  ibus_addr_o,
      output ibus_gnt_i,
      output ibus_rvalid_i,
      output ibus_rdata_i
   );

endinterface

// File: rtl/ifu_skid_buf.sv
// One-entry holding register for a response that lands while the pipe is held.
module ifu_skid_buf (
   input  logic        sys_clk,
   input  logic        sys_arstn,
   input  logic        load,
   input  logic        drain,
   input  logic        inval,
   input  logic [31:0] load_data,
   input  logic [31:0] load_addr,
   output logic        valid,
   output logic [31:0] data,
   output logic [31:0] addr
);

   always_ff @(posedge sys_clk or negedge sys_arstn) begin
      if (!sys_arstn) begin
         valid <= 1'b0;
         data  <= '0;
         addr  <= '0;
      end else if (inval) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         addr  <= load_addr;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: owns the PC, issues single-outstanding ibus
// requests and feeds IF/ID. Optional macro IFU_MISALIGN_CHECK_EN adds fetch_misalign_o.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = ifu_pkg::NOP_INST
) (
   input  logic                sys_clk,
   input  logic                sys_arstn,
   input  logic [2:0]          flag_hold,
   input  logic                flag_jump,
   input  logic [31:0]         jump_addr,
   ifu_ibus_if.master          ibus,
   output logic [31:0]         inst_data_o,
   output logic [31:0]         inst_addr_o,
   output logic                inst_valid_o,
`ifdef IFU_MISALIGN_CHECK_EN
   output logic                fetch_misalign_o,
`endif
   output ifu_pkg::ifu_state_t fsm_state
);

   import ifu_pkg::*;

   ifu_state_t  state;
   logic [31:0] pc;
   logic        req;
   logic [31:0] addr;
   logic        kill;

   logic        hold;
   logic [31:0] target;
   logic [31:0] pc_inc;

   logic        skid_load;
   logic        skid_drain;
   logic        skid_inval;
   logic        skid_valid;
   logic [31:0] skid_data;
   logic [31:0] skid_addr;

   assign hold   = |flag_hold;
   assign target = align_word(jump_addr);
   assign pc_inc = pc + PC_INC;

   // A response caught during hold parks in the skid unless it is stale.
   assign skid_load  = (state == S_WAIT) & ibus.ibus_rvalid_i & ~kill & ~flag_jump & hold;
   assign skid_drain = (state == S_IDLE) & ~hold & ~flag_jump & skid_valid;
   assign skid_inval = (state == S_IDLE) & flag_jump;

   ifu_skid_buf u_skid (
      .sys_clk   (sys_clk),
      .sys_arstn (sys_arstn),
      .load      (skid_load),
      .drain     (skid_drain),
      .inval     (skid_inval),
      .load_data (ibus.ibus_rdata_i),
      .load_addr (pc),
      .valid     (skid_valid),
      .data      (skid_data),
      .addr      (skid_addr)
   );

   always_ff @(posedge sys_clk or negedge sys_arstn) begin
      if (!sys_arstn) begin
         state        <= S_BOOT;
         pc           <= RESET_PC;
         req          <= 1'b0;
         addr         <= RESET_PC;
         kill         <= 1'b0;
         inst_valid_o <= 1'b0;
         inst_data_o  <= NOP_INST;
         inst_addr_o  <= '0;
      end else begin
         // Outputs freeze under hold; otherwise they fall back to a NOP bubble.
         if (!hold) begin
            inst_valid_o <= 1'b0;
            inst_data_o  <= NOP_INST;
         end
         case (state)
            S_BOOT: begin
               state <= S_REQ;
               req   <= 1'b1;
               addr  <= pc;
            end
            S_REQ: begin
               if (ibus.ibus_gnt_i) begin
                  state <= S_WAIT;
                  req   <= 1'b0;
                  if (flag_jump) begin
                     kill <= 1'b1;
                     pc   <= target;
                  end
               end else if (hold) begin
                  state <= S_IDLE;
                  req   <= 1'b0;
                  if (flag_jump) pc <= target;
               end else if (flag_jump) begin
                  pc   <= target;
                  addr <= target;
               end
            end
            S_WAIT: begin
               if (ibus.ibus_rvalid_i) begin
                  kill <= 1'b0;
                  if (kill || flag_jump) begin
                     // Stale response: drop it and restart from the redirected PC.
                     if (flag_jump) pc <= target;
                     state <= hold ? S_IDLE : S_REQ;
                     req   <= ~hold;
                     addr  <= flag_jump ? target : pc;
                  end else if (!hold) begin
                     inst_valid_o <= 1'b1;
                     inst_data_o  <= ibus.ibus_rdata_i;
                     inst_addr_o  <= pc;
                     pc           <= pc_inc;
                     state        <= S_REQ;
                     req          <= 1'b1;
                     addr         <= pc_inc;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (flag_jump) begin
                  kill <= 1'b1;
                  pc   <= target;
               end
            end
            S_IDLE: begin
               if (flag_jump) pc <= target;
               if (!hold) begin
                  state <= S_REQ;
                  req   <= 1'b1;
                  if (flag_jump) begin
                     addr <= target;
                  end else if (skid_valid) begin
                     inst_valid_o <= 1'b1;
                     inst_data_o  <= skid_data;
                     inst_addr_o  <= skid_addr;
                     pc           <= pc_inc;
                     addr         <= pc_inc;
                  end else begin
                     addr <= pc;
                  end
               end
            end
            default: state <= S_BOOT;
         endcase
      end
   end

`ifdef IFU_MISALIGN_CHECK_EN
   always_ff @(posedge sys_clk or negedge sys_arstn) begin
      if (!sys_arstn) fetch_misalign_o <= 1'b0;
      else            fetch_misalign_o <= flag_jump & (|jump_addr[1:0]);
   end
`else
   logic unused_low_bits;
   assign unused_low_bits = ^jump_addr[1:0];
`endif

   assign ibus.ibus_req_o  = req;
   assign ibus.ibus_addr_o = addr;
   assign fsm_state        = state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a single-outstanding bus responder.
module tb_if_fetch_unit;
   import ifu_pkg::*;

   localparam logic [31:0] MAGIC = 32'hA5A5_0000;

   logic        sys_clk;
   logic        sys_arstn;
   logic [2:0]  flag_hold;
   logic        flag_jump;
   logic [31:0] jump_addr;
   logic [31:0] inst_data_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_o;
`ifdef IFU_MISALIGN_CHECK_EN
   logic        fetch_misalign_o;
`endif
   ifu_state_t  fsm_state;

   ifu_ibus_if ibus ();

   if_fetch_unit dut (
      .sys_clk          (sys_clk),
      .sys_arstn        (sys_arstn),
      .flag_hold        (flag_hold),
      .flag_jump        (flag_jump),
      .jump_addr        (jump_addr),
      .ibus             (ibus),
      .inst_data_o      (inst_data_o),
      .inst_addr_o      (inst_addr_o),
      .inst_valid_o     (inst_valid_o),
`ifdef IFU_MISALIGN_CHECK_EN
      .fetch_misalign_o (fetch_misalign_o),
`endif
      .fsm_state        (fsm_state)
   );

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   logic        gnt_en    = 1'b0;
   logic        rv_block  = 1'b0;
   logic        pend      = 1'b0;
   logic [31:0] pend_addr = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock of bus responder + delivery scoreboard; returns 1 time unit after the edge.
   task automatic tick();
      logic        req_s, gnt_s, rv_s, hold_s;
      logic [31:0] addr_s, e;
      gnt_s = gnt_en;
      rv_s  = pend && !rv_block;
      ibus.ibus_gnt_i    = gnt_s;
      ibus.ibus_rvalid_i = rv_s;
      ibus.ibus_rdata_i  = rv_s ? (pend_addr ^ MAGIC) : 32'h0;
      req_s  = ibus.ibus_req_o;
      addr_s = ibus.ibus_addr_o;
      hold_s = |flag_hold;
      @(posedge sys_clk);
      if (sys_arstn) begin
         if (rv_s) pend = 1'b0;
         if (req_s && gnt_s) begin
            pend      = 1'b1;
            pend_addr = addr_s;
         end
      end
      #1;
      if (!hold_s && inst_valid_o) begin
         if (exp_q.size() == 0) begin
            chk("extra_delivery", inst_addr_o, 32'hDEAD_BEEF);
         end else begin
            e = exp_q.pop_front();
            chk("deliv_addr", inst_addr_o, e);
            chk("deliv_data", inst_data_o, e ^ MAGIC);
         end
      end
   endtask

   initial begin
      sys_arstn = 1'b1;
      flag_hold = 3'b000;
      flag_jump = 1'b0;
      jump_addr = '0;
      ibus.ibus_gnt_i    = 1'b0;
      ibus.ibus_rvalid_i = 1'b0;
      ibus.ibus_rdata_i  = '0;
      #1 sys_arstn = 1'b0;
      #1;
      chk("rst_req",   {31'b0, ibus.ibus_req_o}, 32'd0);
      chk("rst_addr",  ibus.ibus_addr_o, 32'h0);
      chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("rst_data",  inst_data_o, 32'h13);
      chk("rst_iaddr", inst_addr_o, 32'h0);
      chk("rst_state", {30'b0, fsm_state}, {30'b0, S_BOOT});
      tick(); tick();
      sys_arstn = 1'b1;
      gnt_en    = 1'b1;

      // Boot: 0, 4, 8 with a bubble between deliveries
      tick();
      chk("boot_req",   {31'b0, ibus.ibus_req_o}, 32'd1);
      chk("boot_addr0", ibus.ibus_addr_o, 32'h0);
      exp_q.push_back(32'h0);
      tick();
      chk("boot_wait_req", {31'b0, ibus.ibus_req_o}, 32'd0);
      chk("boot_state",    {30'b0, fsm_state}, {30'b0, S_WAIT});
      tick();
      chk("boot_addr4", ibus.ibus_addr_o, 32'h4);
      tick();
      chk("bubble_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("bubble_data",  inst_data_o, 32'h13);
      exp_q.push_back(32'h4);
      tick();
      chk("boot_addr8", ibus.ibus_addr_o, 32'h8);
      tick();

      // Hold with 0x8 outstanding: response parks in skid
      flag_hold = 3'b010;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_req", {31'b0, ibus.ibus_req_o}, 32'd0);
      end
      chk("hold_state", {30'b0, fsm_state}, {30'b0, S_IDLE});
      chk("hold_iaddr", inst_addr_o, 32'h4);
      chk("hold_valid", {31'b0, inst_valid_o}, 32'd0);
      flag_hold = 3'b000;
      exp_q.push_back(32'h8);
      tick();
      chk("unhold_req",  {31'b0, ibus.ibus_req_o}, 32'd1);
      chk("unhold_addr", ibus.ibus_addr_o, 32'hC);

      // Jump while waiting on 0xC
      tick();
      flag_jump = 1'b1; jump_addr = 32'h100; rv_block = 1'b1;
      tick();
      flag_jump = 1'b0; rv_block = 1'b0;
      tick();
      chk("jwait_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("jwait_addr",  ibus.ibus_addr_o, 32'h100);
      exp_q.push_back(32'h100);
      tick(); tick();
      chk("jwait_next", ibus.ibus_addr_o, 32'h104);

      // Jump coincident with rvalid, misaligned target
      tick();
      flag_jump = 1'b1; jump_addr = 32'h203;
      tick();
      flag_jump = 1'b0;
      chk("jrv_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("jrv_addr",  ibus.ibus_addr_o, 32'h200);
`ifdef IFU_MISALIGN_CHECK_EN
      chk("misalign_hi", {31'b0, fetch_misalign_o}, 32'd1);
`endif

      // Ungranted request redirected
      gnt_en = 1'b0;
      tick();
`ifdef IFU_MISALIGN_CHECK_EN
      chk("misalign_lo", {31'b0, fetch_misalign_o}, 32'd0);
`endif
      chk("ungnt_addr", ibus.ibus_addr_o, 32'h200);
      flag_jump = 1'b1; jump_addr = 32'h40;
      tick();
      flag_jump = 1'b0;
      chk("ungnt_jaddr", ibus.ibus_addr_o, 32'h40);
      chk("ungnt_req",   {31'b0, ibus.ibus_req_o}, 32'd1);
      tick();
      gnt_en = 1'b1;
      exp_q.push_back(32'h40);
      tick(); tick();
      chk("ungnt_next", ibus.ibus_addr_o, 32'h44);

      // Hold during an ungranted request drops req
      gnt_en = 1'b0;
      tick();
      flag_hold = 3'b100;
      tick();
      chk("rhold_req",   {31'b0, ibus.ibus_req_o}, 32'd0);
      chk("rhold_state", {30'b0, fsm_state}, {30'b0, S_IDLE});
      tick();
      flag_hold = 3'b000; gnt_en = 1'b1;
      tick();
      chk("rhold_rereq", {31'b0, ibus.ibus_req_o}, 32'd1);
      chk("rhold_addr",  ibus.ibus_addr_o, 32'h44);

      // Jump in the grant cycle, then PC wrap
      flag_jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
      tick();
      flag_jump = 1'b0;
      chk("jgnt_state", {30'b0, fsm_state}, {30'b0, S_WAIT});
      tick();
      chk("jgnt_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("jgnt_addr",  ibus.ibus_addr_o, 32'hFFFF_FFFC);
      exp_q.push_back(32'hFFFF_FFFC);
      tick(); tick();
      chk("wrap_addr", ibus.ibus_addr_o, 32'h0);

      // Reset while waiting
      tick();
      sys_arstn = 1'b0;
      #1;
      chk("mrst_req",   {31'b0, ibus.ibus_req_o}, 32'd0);
      chk("mrst_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("mrst_data",  inst_data_o, 32'h13);
      chk("mrst_iaddr", inst_addr_o, 32'h0);
      pend = 1'b0;
      tick(); tick();
      sys_arstn = 1'b1;
      exp_q.push_back(32'h0);
      tick();
      chk("refetch_req",  {31'b0, ibus.ibus_req_o}, 32'd1);
      chk("refetch_addr", ibus.ibus_addr_o, 32'h0);
      tick(); tick();
      chk("refetch_next", ibus.ibus_addr_o, 32'h4);

      chk("sb_drain", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
